picosoc_busdec: RTL



---
 rtl/picosoc_bus_pkg.sv | 19 +
 rtl/picosoc_addr_match.sv | 28 ++
 rtl/picosoc_busdec.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoRV32 bus decoder.
// Holds FSM states, error codes and default error read data.
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_GAP
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

  localparam int MAX_SLAVES = 8;

endpackage

// File: rtl/picosoc_addr_match.sv
// Base/mask window compare with lowest-index priority encode.
// Ports: addr in; hit_any and sel_idx out (combinational).
module picosoc_addr_match
  import picosoc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = '0,
  parameter int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [31:0]   addr,
  output logic          hit_any,
  output logic [IW-1:0] sel_idx
);

  // Walk from the top down so the lowest-index hit is the last write.
  always_comb begin
    hit_any = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/picosoc_busdec.sv
// PicoRV32 native-bus decoder: window select, response mux,
// wait-state watchdog and error record. Ports: CPU mem_*, slave s_*, err_*.
module picosoc_busdec
  import picosoc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic                     mem_instr,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic                     s_instr,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [31:0]              err_addr,
  output logic [15:0]              err_count
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CL = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (CL < 1) ? 1 : CL;
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  state_t          state, state_n;
  logic [IW-1:0]   sel_q, sel_d, dec_idx, cur;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hit_any;
  logic            slv_rdy;
  logic [31:0]     slv_rd;
  logic            req, rdy, err_now, tmo;
  logic [1:0]      err_type;
  logic [15:0]     err_count_q;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wstrb = mem_wstrb;
  assign s_instr = mem_instr;

  picosoc_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .IW         (IW)
  ) u_match (
    .addr    (mem_addr),
    .hit_any (hit_any),
    .sel_idx (dec_idx)
  );

  // In BUSY the latched index is used; the address is not re-decoded.
  assign cur = (state == ST_IDLE) ? dec_idx : sel_q;
  assign tmo = WD_ON && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    slv_rd  = '0;
    slv_rdy = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cur == IW'(i)) begin
        slv_rd  = s_rdata[32*i +: 32];
        slv_rdy = s_ready[i];
      end
    end
  end

  always_comb begin
    state_n   = state;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    rdy       = 1'b0;
    mem_rdata = '0;
    err_now   = 1'b0;
    err_type  = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (hit_any) begin
            req   = 1'b1;
            sel_d = dec_idx;
            if (slv_rdy) begin
              rdy       = 1'b1;
              mem_rdata = slv_rd;
              state_n   = ST_GAP;
            end else begin
              state_n = ST_BUSY;
              cnt_d   = WD_ON ? CW'(1) : '0;
            end
          end else begin
            rdy       = 1'b1;
            mem_rdata = ERR_RDATA;
            err_now   = 1'b1;
            err_type  = ERR_UNMAPPED;
            state_n   = ST_GAP;
          end
        end
      end
      ST_BUSY: begin
        if (!mem_valid) begin
          state_n = ST_IDLE;
          cnt_d   = '0;
        end else if (slv_rdy) begin
          req       = 1'b1;
          rdy       = 1'b1;
          mem_rdata = slv_rd;
          state_n   = ST_GAP;
          cnt_d     = '0;
        end else if (tmo) begin
          rdy       = 1'b1;
          mem_rdata = ERR_RDATA;
          err_now   = 1'b1;
          err_type  = ERR_TIMEOUT;
          state_n   = ST_GAP;
          cnt_d     = '0;
        end else begin
          req   = 1'b1;
          cnt_d = WD_ON ? cnt_q + CW'(1) : '0;
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_ready = rdy & ~reset;

  always_comb begin
    s_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_valid[i] = req && !reset && (cur == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      err_addr    <= '0;
      err_count_q <= '0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_valid <= err_now;
      if (err_now) begin
        err_code <= err_type;
        err_addr <= mem_addr;
        if (err_count_q != 16'hFFFF) begin
          err_count_q <= err_count_q + 16'd1;
        end
      end
    end
  end

  assign err_count = err_count_q;

endmodule
